ex_issue_stage: RTL

ID/EX pipeline register plus execute-stage operand network, sitting directly upstream of the ALU. It captures decoded instructions from ID and detects load-use hazards by stalling ID and inserting a bubble. It resolves RAW dependences by forwarding from EX/MEM and MEM/WB. It drives the ALU's op/in0/in1 with MIPS-correct operands: shift amounts go on in0, the shifted value on in1.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/ex_issue_stage_if.sv | 62 ++++++
 rtl/fwd_mux.sv | 28 ++
 rtl/ex_issue_stage.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcode encoding, ALU in0 source selectors, datapath defaults.
// No logic here; imported by the execute-stage files and the bench.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SRAV = 4'b1100;

    typedef enum logic [1:0] {
        SRC0_RS       = 2'b00,
        SRC0_SHAMT    = 2'b01,
        SRC0_RS_SHAMT = 2'b10,
        SRC0_RSVD     = 2'b11
    } src0_sel_e;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ID->EX issue bus: decoded instruction, forwarding sources, ALU operands and EX controls.
// The slave side is the issue stage; the master side is the surrounding pipeline.
interface ex_issue_stage_if #(
    parameter int DATA_W = cpu_pkg::DEF_DATA_W,
    parameter int REG_AW = cpu_pkg::DEF_REG_AW
);
    localparam int SH_W = $clog2(DATA_W);

    logic              id_valid;
    logic [3:0]        id_op;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [SH_W-1:0]   id_shamt;
    logic [1:0]        id_src0_sel;
    logic              id_use_imm;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              stall_in;
    logic              flush;
    logic              exm_reg_write;
    logic [REG_AW-1:0] exm_rd;
    logic [DATA_W-1:0] exm_data;
    logic              mwb_reg_write;
    logic [REG_AW-1:0] mwb_rd;
    logic [DATA_W-1:0] mwb_data;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_in0;
    logic [DATA_W-1:0] alu_in1;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [DATA_W-1:0] ex_store_data;
    logic              hazard_stall;

    modport slave (
        input  id_valid, id_op, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_src0_sel, id_use_imm,
               id_rd_addr, id_reg_write, id_mem_read, id_mem_write, stall_in, flush,
               exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data,
        output alu_op, alu_in0, alu_in1, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_store_data, hazard_stall
    );

    modport master (
        output id_valid, id_op, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_src0_sel, id_use_imm,
               id_rd_addr, id_reg_write, id_mem_read, id_mem_write, stall_in, flush,
               exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data,
        input  alu_op, alu_in0, alu_in1, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_store_data, hazard_stall
    );

endinterface

// File: rtl/fwd_mux.sv
// Single-operand RAW forwarding select: EX/MEM beats MEM/WB beats the registered value.
// Purely combinational (0 cycles); no backpressure. Register 0 is never forwarded.
module fwd_mux #(
    parameter int DATA_W = cpu_pkg::DEF_DATA_W,
    parameter int REG_AW = cpu_pkg::DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] fwd_val
);
    always_comb begin
        fwd_val = reg_val;
        if (src_addr != '0) begin
            if (exm_reg_write && (exm_rd == src_addr)) begin
                fwd_val = exm_data;
            end else if (mwb_reg_write && (mwb_rd == src_addr)) begin
                fwd_val = mwb_data;
            end
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register with load-use bubble insertion, WB capture bypass and EX operand forwarding.
// One cycle ID->ALU operands; stall_in freezes EX, hazard_stall holds PC and IF/ID.
module ex_issue_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic           clk,
    input  logic           rst,
    ex_issue_stage_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic              valid;
        logic [3:0]        op;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [SH_W-1:0]   shamt;
        src0_sel_e         src0_sel;
        logic              use_imm;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_reg_t;

    ex_reg_t           ex_q;
    ex_reg_t           id_next;
    logic              hazard;
    logic              mwb_wr;
    logic [DATA_W-1:0] rs_f;
    logic [DATA_W-1:0] rt_f;
    logic [3:0]        alu_op_c;
    logic [DATA_W-1:0] alu_in0_c;
    logic [DATA_W-1:0] alu_in1_c;

    assign mwb_wr = bus.mwb_reg_write && (bus.mwb_rd != '0);

    assign hazard = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                    ((bus.id_uses_rs && (bus.id_rs_addr == ex_q.rd)) ||
                     (bus.id_uses_rt && (bus.id_rt_addr == ex_q.rd)));

    // The register file is not write-through, so a same-cycle WB write is picked up here.
    always_comb begin
        id_next           = '0;
        id_next.valid     = bus.id_valid;
        id_next.op        = bus.id_op;
        id_next.rs_addr   = bus.id_rs_addr;
        id_next.rt_addr   = bus.id_rt_addr;
        id_next.rs_data   = (mwb_wr && (bus.mwb_rd == bus.id_rs_addr)) ? bus.mwb_data : bus.id_rs_data;
        id_next.rt_data   = (mwb_wr && (bus.mwb_rd == bus.id_rt_addr)) ? bus.mwb_data : bus.id_rt_data;
        id_next.imm       = bus.id_imm;
        id_next.shamt     = bus.id_shamt;
        id_next.src0_sel  = src0_sel_e'(bus.id_src0_sel);
        id_next.use_imm   = bus.id_use_imm;
        id_next.rd        = bus.id_rd_addr;
        id_next.reg_write = bus.id_reg_write;
        id_next.mem_read  = bus.id_mem_read;
        id_next.mem_write = bus.id_mem_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
        end else if (bus.stall_in) begin
            // Keep held operands current while WB retires the producer during a long stall.
            if (mwb_wr && (bus.mwb_rd == ex_q.rs_addr)) ex_q.rs_data <= bus.mwb_data;
            if (mwb_wr && (bus.mwb_rd == ex_q.rt_addr)) ex_q.rt_data <= bus.mwb_data;
        end else if (hazard) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
        end else begin
            ex_q <= id_next;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_addr      (ex_q.rs_addr),
        .reg_val       (ex_q.rs_data),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_data      (bus.exm_data),
        .mwb_reg_write (bus.mwb_reg_write),
        .mwb_rd        (bus.mwb_rd),
        .mwb_data      (bus.mwb_data),
        .fwd_val       (rs_f)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_addr      (ex_q.rt_addr),
        .reg_val       (ex_q.rt_data),
        .exm_reg_write (bus.exm_reg_write),
        .exm_rd        (bus.exm_rd),
        .exm_data      (bus.exm_data),
        .mwb_reg_write (bus.mwb_reg_write),
        .mwb_rd        (bus.mwb_rd),
        .mwb_data      (bus.mwb_data),
        .fwd_val       (rt_f)
    );

    // Bubbles present addu 0+0 so the ALU can never flag overflow on a dead slot.
    always_comb begin
        alu_op_c  = ALU_ADDU;
        alu_in0_c = '0;
        alu_in1_c = '0;
        if (ex_q.valid) begin
            alu_op_c = ex_q.op;
            case (ex_q.src0_sel)
                SRC0_SHAMT:    alu_in0_c = {{(DATA_W-SH_W){1'b0}}, ex_q.shamt};
                SRC0_RS_SHAMT: alu_in0_c = {{(DATA_W-SH_W){1'b0}}, rs_f[SH_W-1:0]};
                default:       alu_in0_c = rs_f;
            endcase
            alu_in1_c = ex_q.use_imm ? ex_q.imm : rt_f;
        end
    end

    assign bus.alu_op        = alu_op_c;
    assign bus.alu_in0       = alu_in0_c;
    assign bus.alu_in1       = alu_in1_c;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_store_data = rt_f;
    assign bus.hazard_stall  = hazard;

endmodule
